ad_ip_jesd204_tpl_dac_dma_buf: RTL and testbench

AD_IP_JESD204_TPL_DAC_DMA_BUF -- requirements
Module: ad_ip_jesd204_tpl_dac_dma_buf

---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 15 +
 rtl/ad_ip_jesd204_tpl_dac_buf_mem.sv | 40 ++++
 rtl/ad_ip_jesd204_tpl_dac_dma_buf.sv | 140 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_dma_buf.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared types for the JESD204 TPL DAC DMA buffer.
package ad_ip_jesd204_tpl_dac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } dac_buf_state_t;

    // Number of beats held by a buffer with the given address width.
    function automatic int unsigned buf_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_buf_mem.sv
// Simple dual-port beat storage: one write port, one registered read port.
module ad_ip_jesd204_tpl_dac_buf_mem
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = buf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds the last popped beat; rd_clr forces the output to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_buf.sv
// Prefilling DMA-to-TPL DAC beat buffer with underflow detection and flush.
module ad_ip_jesd204_tpl_dac_dma_buf
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PREFILL    = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  dac_valid,
    input  logic                  dac_rst,
    output logic [DATA_WIDTH-1:0] dac_ddata,
    output logic                  dac_underflow,
    input  logic                  underflow_clr,
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int unsigned DEPTH = buf_depth(ADDR_WIDTH);
    localparam int unsigned FW    = ADDR_WIDTH + 1;

    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    dac_buf_state_t        state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_nxt;
    logic [FW-1:0]         fill_nxt;
    logic                  ready_nxt;
    logic                  underflow_nxt;
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  rd_clr_c;
    logic                  uf_c;

    // Assert immediately, release on a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_nxt  = state_q;
        wr_ptr_nxt = wr_ptr_q;
        rd_ptr_nxt = rd_ptr_q;
        fill_nxt   = fill_level;
        wr_en_c    = 1'b0;
        rd_en_c    = 1'b0;
        rd_clr_c   = 1'b0;
        uf_c       = 1'b0;

        if (dac_rst) begin
            // Flush drops any beat offered this cycle.
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            fill_nxt   = '0;
            rd_clr_c   = 1'b1;
        end else begin
            wr_en_c = s_axis_valid && s_axis_ready;
            case (state_q)
                IDLE: state_nxt = FILL;
                FILL: begin
                    if (fill_level >= FW'(PREFILL)) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // No write-to-read bypass: an empty FIFO underflows even if a beat lands now.
                    if (dac_valid) begin
                        if (fill_level != '0) begin
                            rd_en_c = 1'b1;
                        end else begin
                            uf_c      = 1'b1;
                            rd_clr_c  = 1'b1;
                            state_nxt = FILL;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (wr_en_c) begin
                wr_ptr_nxt = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_en_c) begin
                rd_ptr_nxt = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   fill_nxt = fill_level + FW'(1);
                2'b01:   fill_nxt = fill_level - FW'(1);
                default: fill_nxt = fill_level;
            endcase
        end

        ready_nxt     = (state_nxt != IDLE) && (fill_nxt < FW'(DEPTH));
        underflow_nxt = uf_c || (dac_underflow && !underflow_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_level    <= '0;
            s_axis_ready  <= 1'b0;
            dac_underflow <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            wr_ptr_q      <= wr_ptr_nxt;
            rd_ptr_q      <= rd_ptr_nxt;
            fill_level    <= fill_nxt;
            s_axis_ready  <= ready_nxt;
            dac_underflow <= underflow_nxt;
        end
    end

    ad_ip_jesd204_tpl_dac_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (s_axis_data),
        .rd_en   (rd_en_c),
        .rd_clr  (rd_clr_c),
        .rd_addr (rd_ptr_q),
        .rd_data (dac_ddata)
    );

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_buf.sv
// Scoreboard bench for the TPL DAC DMA buffer: directed fill, full, underflow, stream, flush and reset.
module tb_ad_ip_jesd204_tpl_dac_dma_buf;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data = '0;
    logic          dac_valid = 1'b0;
    logic          dac_rst = 1'b0;
    logic [DW-1:0] dac_ddata;
    logic          dac_underflow;
    logic          underflow_clr = 1'b0;
    logic [AW:0]   fill_level;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] fifo_m[$];
    logic [DW-1:0] exp_q[$];
    logic          run_m = 1'b0;
    logic          exp_pend = 1'b0;

    ad_ip_jesd204_tpl_dac_dma_buf #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PREFILL    (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_valid  (s_axis_valid),
        .s_axis_ready  (s_axis_ready),
        .s_axis_data   (s_axis_data),
        .dac_valid     (dac_valid),
        .dac_rst       (dac_rst),
        .dac_ddata     (dac_ddata),
        .dac_underflow (dac_underflow),
        .underflow_clr (underflow_clr),
        .fill_level    (fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, update the model, check fill level at the next negedge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic pop, input logic rst);
        logic acc;
        s_axis_valid = v;
        s_axis_data  = d;
        dac_valid    = pop;
        dac_rst      = rst;
        acc          = v && s_axis_ready && !rst;
        exp_pend     = 1'b0;
        if (rst) begin
            fifo_m.delete();
        end else begin
            if (pop && run_m) begin
                exp_pend = 1'b1;
                if (fifo_m.size() > 0) begin
                    exp_q.push_back(fifo_m.pop_front());
                end else begin
                    exp_q.push_back('0);
                    run_m = 1'b0;
                end
            end
            if (acc) begin
                fifo_m.push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("fill_level", DW'(fill_level), DW'(fifo_m.size()));
    endtask

    // Monitor: after each edge carrying a modelled pop, compare dac_ddata with the scoreboard.
    initial begin : monitor
        logic take;
        forever begin
            @(posedge clk);
            take = exp_pend;
            @(negedge clk);
            if (take) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dac_ddata: scoreboard empty, got 0x%0h", dac_ddata);
                end else begin
                    chk("dac_ddata", dac_ddata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ddata", dac_ddata, '0);
        chk("rst_fill", DW'(fill_level), '0);
        chk("rst_ready", DW'(s_axis_ready), '0);
        chk("rst_underflow", DW'(dac_underflow), '0);

        resetn = 1'b1;
        n = 0;
        while (!s_axis_ready && n < 10) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        chk("ready_after_reset", DW'(s_axis_ready), DW'(1));

        // Prefill with 0x1..0x8, output held at zero until the first pop.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        chk("ddata_during_fill", dac_ddata, '0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("ddata_before_pop", dac_ddata, '0);
        run_m = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("ddata_hold", dac_ddata, DW'(1));

        // Drain to one beat, then pop it and underflow.
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("underflow_set", DW'(dac_underflow), DW'(1));
        chk("ddata_after_underflow", dac_ddata, '0);
        chk("ready_in_fill", DW'(s_axis_ready), DW'(1));
        underflow_clr = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        underflow_clr = 1'b0;
        chk("underflow_clr", DW'(dac_underflow), '0);

        // Fill to depth; the 17th beat must be refused.
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        chk("ready_full", DW'(s_axis_ready), '0);
        cycle(1'b1, DW'(32'hdead), 1'b0, 1'b0);
        chk("ready_full_hold", DW'(s_axis_ready), '0);

        // Continuous push and pop across several pointer wraps.
        run_m = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
        chk("no_underflow_stream", DW'(dac_underflow), '0);

        // Flush at fill level 10; the offered beat is dropped.
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fill_before_flush", DW'(fill_level), DW'(10));
        run_m = 1'b0;
        cycle(1'b1, DW'(32'hbeef), 1'b0, 1'b1);
        chk("flush_ddata", dac_ddata, '0);
        chk("flush_ready", DW'(s_axis_ready), '0);
        cycle(1'b1, DW'(32'hcafe), 1'b0, 1'b0);
        chk("ready_after_idle", DW'(s_axis_ready), DW'(1));
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("no_pop_below_prefill", dac_ddata, '0);
        cycle(1'b1, DW'(32'h307), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        run_m = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        exp_pend  = 1'b0;
        dac_valid = 1'b0;

        // Asynchronous reset between clock edges.
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_ddata", dac_ddata, '0);
        chk("async_rst_fill", DW'(fill_level), '0);
        chk("async_rst_ready", DW'(s_axis_ready), '0);
        chk("async_rst_underflow", DW'(dac_underflow), '0);
        chk("scoreboard_drained", DW'(exp_q.size()), '0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
